// File: rtl/result_serializer.sv
// result_serializer: streams a NUM_ELEMS-element result frame as two-element AXI-Stream beats
// ports: axi_clk/axi_rst clock and synchronous active-high reset; s_axis_* frame input;
//        m_axis_* beat output (tlast on the final beat); frame_count frames fully emitted (wraps);
//        busy high while a frame is being sent
module result_serializer #(
  parameter int ELEM_W = 16,
  parameter int NUM_ELEMS = 9,
  parameter int CNT_W = 16
) (
  input  logic                        axi_clk,
  input  logic                        axi_rst,
  input  logic                        s_axis_valid,
  input  logic [NUM_ELEMS*ELEM_W-1:0] s_axis_data,
  output logic                        s_axis_ready,
  output logic                        m_axis_tvalid,
  output logic [2*ELEM_W-1:0]         m_axis_tdata,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [CNT_W-1:0]            frame_count,
  output logic                        busy
);
  localparam int NB = (NUM_ELEMS + 1) / 2;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST = BW'(NB - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [BW-1:0] beat, beat_nx;
  logic [NUM_ELEMS*ELEM_W-1:0] hold;
  logic [2*NB*ELEM_W-1:0] padded;
  logic last_hs, cap;
  // zero-extension supplies the missing upper element of an odd-sized frame
  assign padded = (2*NB*ELEM_W)'(hold);
  assign last_hs = state == SEND && beat == LAST && m_axis_tready;
  assign s_axis_ready = state == IDLE || last_hs;
  assign cap = s_axis_valid && s_axis_ready;
  assign m_axis_tvalid = state == SEND;
  assign m_axis_tlast = state == SEND && beat == LAST;
  assign m_axis_tdata = state == SEND ? padded[beat*2*ELEM_W +: 2*ELEM_W] : '0;
  assign busy = state == SEND;
  always_comb begin
    state_nx = cap ? SEND : last_hs ? IDLE : state;
    beat_nx = (cap || last_hs) ? '0 : (state == SEND && m_axis_tready) ? beat + 1'b1 : beat;
  end
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state <= IDLE;
      beat <= '0;
      hold <= '0;
      frame_count <= '0;
    end else begin
      state <= state_nx;
      beat <= beat_nx;
      if (cap) hold <= s_axis_data;
      if (last_hs) frame_count <= frame_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: randomized scoreboard bench for result_serializer with directed literal checks
module tb_result_serializer;
  localparam int EW = 16, NE = 9, NB = 5;
  logic clk = 0, rst = 1, s_valid = 0, tready = 1;
  logic [NE*EW-1:0] s_data = '0;
  logic s_ready, tvalid, tlast, busy;
  logic [31:0] tdata;
  logic [15:0] fcount;
  logic s_ready_w, tvalid_w, tlast_w, busy_w;
  logic [31:0] tdata_w;
  logic [2:0] fcount_w;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic [15:0] cnt = 0;
  bit armed = 0;
  always #5 clk = ~clk;

  result_serializer dut (
    .axi_clk(clk), .axi_rst(rst), .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_ready(s_ready),
    .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tlast(tlast), .m_axis_tready(tready),
    .frame_count(fcount), .busy(busy));

  result_serializer #(.CNT_W(3)) dut_w (
    .axi_clk(clk), .axi_rst(rst), .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_ready(s_ready_w),
    .m_axis_tvalid(tvalid_w), .m_axis_tdata(tdata_w), .m_axis_tlast(tlast_w), .m_axis_tready(tready),
    .frame_count(fcount_w), .busy(busy_w));

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction

  function automatic logic [NE*EW-1:0] rand_frame();
    logic [159:0] t;
    for (int j = 0; j < 5; j++) t[32*j +: 32] = $urandom;
    return t[NE*EW-1:0];
  endfunction

  function automatic logic [NE*EW-1:0] ramp_frame();
    logic [NE*EW-1:0] f;
    for (int k = 0; k < NE; k++) f[EW*k +: EW] = 16'h0100 + 16'(k);
    return f;
  endfunction

  function automatic logic [NE*EW-1:0] fill_frame(logic [15:0] v);
    logic [NE*EW-1:0] f;
    for (int k = 0; k < NE; k++) f[EW*k +: EW] = v;
    return f;
  endfunction

  // scoreboard: a queue of beats still owed downstream; an accepted frame appends all of its beats
  always @(negedge clk) begin
    logic mready;
    mready = q.size() == 0 || (q.size() == 1 && tready);
    if (armed) begin
      chk("tvalid", 32'(tvalid), 32'(q.size() != 0));
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("s_ready", 32'(s_ready), 32'(mready));
      chk("frame_count", 32'(fcount), 32'(cnt));
      chk("w_frame_count", 32'(fcount_w), 32'(cnt[2:0]));
      chk("w_tvalid", 32'(tvalid_w), 32'(q.size() != 0));
      chk("w_s_ready", 32'(s_ready_w), 32'(mready));
      if (q.size() != 0) begin
        chk("tdata", tdata, q[0]);
        chk("tlast", 32'(tlast), 32'(q.size() == 1));
        chk("w_tdata", tdata_w, q[0]);
      end
    end
    if (rst) begin
      armed = 1;
      q.delete();
      cnt = 0;
    end else begin
      if (q.size() != 0 && tready) begin
        if (q.size() == 1) cnt++;
        void'(q.pop_front());
      end
      if (s_valid && mready)
        for (int b = 0; b < NB; b++)
          q.push_back({(2*b+1 < NE) ? s_data[EW*(2*b+1) +: EW] : 16'h0, s_data[EW*2*b +: EW]});
    end
  end

  initial begin
    logic [31:0] ramp_beats [NB];
    bit acc;
    ramp_beats = '{32'h01010100, 32'h01030102, 32'h01050104, 32'h01070106, 32'h00000108};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tlast", 32'(tlast), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_count", 32'(fcount), 0);
    // single ramp frame at full throughput
    @(posedge clk); #1 s_valid = 1; s_data = ramp_frame();
    @(posedge clk); #1 s_valid = 0;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk("single_tvalid", 32'(tvalid), 1);
      chk("single_tdata", tdata, ramp_beats[i]);
      chk("single_tlast", 32'(tlast), 32'(i == NB - 1));
    end
    @(negedge clk);
    chk("single_busy", 32'(busy), 0);
    chk("single_count", 32'(fcount), 1);
    // back-to-back frames with valid held high
    @(posedge clk); #1 s_valid = 1; s_data = fill_frame(16'hAAAA);
    @(posedge clk); #1 s_data = fill_frame(16'h5555);
    for (int i = 0; i < 2*NB; i++) begin
      @(negedge clk);
      chk("b2b_tvalid", 32'(tvalid), 1);
      chk("b2b_tlast", 32'(tlast), 32'(i % NB == NB - 1));
      if (i == NB - 1) chk("b2b_beat5", tdata, 32'h0000AAAA);
      if (i == 2*NB - 1) chk("b2b_beat10", tdata, 32'h00005555);
      if (i == NB - 1) begin
        @(posedge clk); #1 s_valid = 0;
      end
    end
    @(negedge clk);
    chk("b2b_count", 32'(fcount), 3);
    chk("b2b_busy", 32'(busy), 0);
    // reset after beat 2 is accepted
    @(posedge clk); #1 s_valid = 1; s_data = ramp_frame();
    @(posedge clk); #1 s_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("mid_rst_tvalid", 32'(tvalid), 0);
    chk("mid_rst_count", 32'(fcount), 0);
    chk("mid_rst_s_ready", 32'(s_ready), 1);
    @(posedge clk); #1 s_valid = 1; s_data = ramp_frame();
    @(posedge clk); #1 s_valid = 0;
    @(negedge clk);
    chk("post_rst_beat0", tdata, 32'h01010100);
    chk("post_rst_tlast", 32'(tlast), 0);
    repeat (6) @(posedge clk);
    // randomized traffic with backpressure, data churn while stalled and occasional reset
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      rst = $urandom_range(0, 799) == 0;
      tready = $urandom_range(0, 9) < 7;
      if (!s_valid || acc) begin
        s_valid = $urandom_range(0, 2) != 0;
        s_data = rand_frame();
      end else if ($urandom_range(0, 3) == 0) s_data = rand_frame();
    end
    @(posedge clk); #1 rst = 0; s_valid = 0; tready = 1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
